// File: rtl/icache_pkg.sv
// ---------------------------------------------------------------------------
// icache_pkg : shared FSM encoding, default geometry and derived widths
// Revision   : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

package icache_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_REFILL = 1'b1
  } state_t;

  localparam int DEF_SETS           = 16;
  localparam int DEF_WORDS_PER_LINE = 4;

  localparam int OFF = $clog2(DEF_WORDS_PER_LINE);
  localparam int IDX = $clog2(DEF_SETS);
  localparam int TAG = 30 - OFF - IDX;

endpackage

`default_nettype wire

// File: rtl/icache_tag_array.sv
// ---------------------------------------------------------------------------
// icache_tag_array : per-line valid/tag flops, combinational compare, flash clear
// Revision         : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module icache_tag_array
  import icache_pkg::*;
#(
  parameter int SETS  = DEF_SETS,
  parameter int TAG_W = TAG,
  localparam int IDX_W = $clog2(SETS)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] lk_index,
  input  logic [TAG_W-1:0] lk_tag,
  output logic             hit,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_index,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic             wr_valid,
  input  logic             inval_all
);

  logic [SETS-1:0]  valid;
  logic [TAG_W-1:0] tags [SETS];

  assign hit = valid[lk_index] && (tags[lk_index] == lk_tag);

  // Flash invalidate takes priority over a refill completing in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid <= '0;
    end else begin
      if (wr_en) begin
        tags[wr_index]  <= wr_tag;
        valid[wr_index] <= wr_valid;
      end
      if (inval_all) begin
        valid <= '0;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/icache.sv
// ---------------------------------------------------------------------------
// icache   : direct-mapped instruction cache, one-cycle hit, beat-wise refill
//            optional hit/miss counters under ICACHE_PERF_EN
// Revision : 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module icache
  import icache_pkg::*;
#(
  parameter int SETS           = DEF_SETS,
  parameter int WORDS_PER_LINE = DEF_WORDS_PER_LINE
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_imem_ren,
  input  logic [31:0] i_imem_raddr,
  output logic [31:0] o_imem_rdata,
  output logic        o_busy,
  input  logic        i_inval,
  output logic        o_mem_ren,
  output logic [31:0] o_mem_addr,
  input  logic        i_mem_valid,
  input  logic [31:0] i_mem_rdata
`ifdef ICACHE_PERF_EN
  ,
  output logic [31:0] o_hit_cnt,
  output logic [31:0] o_miss_cnt
`endif
);

  localparam int OFF_W = $clog2(WORDS_PER_LINE);
  localparam int IDX_W = $clog2(SETS);
  localparam int TAG_W = 30 - OFF_W - IDX_W;
  localparam logic [OFF_W-1:0] LAST_BEAT = OFF_W'(WORDS_PER_LINE - 1);

  state_t           state, state_nxt;
  logic [29:0]      a_q;
  logic             lk_vld;
  logic [OFF_W-1:0] beat;
  logic             inval_pend;
  logic [31:0]      data [SETS][WORDS_PER_LINE];

  logic [OFF_W-1:0] off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             tag_hit;
  logic             lookup_hit;
  logic             miss;
  logic             refill_done;
  logic             unused_addr_bits;

  assign off = a_q[OFF_W-1:0];
  assign idx = a_q[OFF_W +: IDX_W];
  assign tag = a_q[29 -: TAG_W];
  assign unused_addr_bits = ^i_imem_raddr[1:0];

  icache_tag_array #(
    .SETS  (SETS),
    .TAG_W (TAG_W)
  ) u_tag_array (
    .clk       (i_clk),
    .rst       (i_rst),
    .lk_index  (idx),
    .lk_tag    (tag),
    .hit       (tag_hit),
    .wr_en     (refill_done),
    .wr_index  (idx),
    .wr_tag    (tag),
    .wr_valid  (!(inval_pend || i_inval)),
    .inval_all (((state == ST_IDLE) && i_inval) ||
                (refill_done && (inval_pend || i_inval)))
  );

  always_comb begin
    state_nxt   = state;
    lookup_hit  = 1'b0;
    miss        = 1'b0;
    o_busy      = 1'b0;
    o_mem_ren   = 1'b0;
    refill_done = 1'b0;
    case (state)
      ST_IDLE: begin
        if (lk_vld) begin
          if (tag_hit) begin
            lookup_hit = 1'b1;
          end else begin
            miss      = 1'b1;
            o_busy    = 1'b1;
            state_nxt = ST_REFILL;
          end
        end
      end
      ST_REFILL: begin
        o_busy    = 1'b1;
        o_mem_ren = 1'b1;
        if (i_mem_valid && (beat == LAST_BEAT)) begin
          refill_done = 1'b1;
          state_nxt   = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign o_imem_rdata = lookup_hit ? data[idx][off] : 32'd0;
  assign o_mem_addr   = o_mem_ren ? {a_q[29:OFF_W], {(OFF_W + 2){1'b0}}} : 32'd0;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state      <= ST_IDLE;
      a_q        <= '0;
      lk_vld     <= 1'b0;
      beat       <= '0;
      inval_pend <= 1'b0;
    end else begin
      state <= state_nxt;
      // The lookup address is frozen while busy so the refill and re-lookup see it.
      if (!o_busy) begin
        lk_vld <= i_imem_ren;
        if (i_imem_ren) begin
          a_q <= i_imem_raddr[31:2];
        end
      end
      if (state == ST_REFILL) begin
        if (i_inval) begin
          inval_pend <= 1'b1;
        end
        if (i_mem_valid) begin
          beat <= refill_done ? '0 : beat + 1'b1;
        end
        if (refill_done) begin
          inval_pend <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if ((state == ST_REFILL) && i_mem_valid) begin
      data[idx][beat] <= i_mem_rdata;
    end
  end

`ifdef ICACHE_PERF_EN
  logic [31:0] hit_cnt;
  logic [31:0] miss_cnt;
  logic        relook;

  // The hit that immediately follows a refill belongs to the miss, not the hit count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hit_cnt  <= '0;
      miss_cnt <= '0;
      relook   <= 1'b0;
    end else begin
      relook <= refill_done;
      if (lookup_hit && !relook) begin
        hit_cnt <= hit_cnt + 32'd1;
      end
      if (miss) begin
        miss_cnt <= miss_cnt + 32'd1;
      end
    end
  end

  assign o_hit_cnt  = hit_cnt;
  assign o_miss_cnt = miss_cnt;
`endif

endmodule

`default_nettype wire
